clock_base_top: RTL and testbench

// - Top level of the shift-register demo board. It receives 8N1 serial bytes on ct_UartRx
//   and parses them into length-prefixed, XOR-checked packets.
// - Payload bytes of each packet are shifted into an 8-byte shift register.
// - Results are shown on the 8 board LEDs; sw selects the LED view (data or statistics).

---
 rtl/clock_base_pkg.sv | 20 ++
 rtl/clock_base_top_uart_rx.sv | 106 ++++++++++
 rtl/clock_base_top.sv | 112 +++++++++++
 tb/tb_clock_base_top.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/clock_base_pkg.sv
// rtl/clock_base_pkg.sv - shared constants and state types for the serial packet LED board
package clock_base_pkg;

  localparam int         CLK_HZ       = 100_000_000;
  localparam int         BAUD         = 57_600;
  localparam int         CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [7:0] SOF          = 8'h7E;
  localparam logic [7:0] MAX_LEN      = 8'd8;

  typedef enum logic [1:0] {HUNT, LEN, DATA} pkt_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/clock_base_top_uart_rx.sv
// rtl/clock_base_top_uart_rx.sv - 8N1 receiver with synchronizer, glitch reject and framing-error drop
module uart_rx #(
  parameter int CLKS_PER_BIT = clock_base_pkg::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  import clock_base_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d;
  logic          sync1_q, sync2_q, prev_q;

  // sync2_q is the usable line; prev_q only serves the falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_line;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BITS: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_data  = sh_q;

endmodule

// File: rtl/clock_base_top.sv
// rtl/clock_base_top.sv - parses length-prefixed XOR-checked serial packets into a shift register
// and shows either the first payload byte of the last good packet or the ok/error counters on the LEDs.
module clock_base_top #(
  parameter int CLKS_PER_BIT = clock_base_pkg::CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       sw,
  input  logic       ct_UartRx,
  output logic [7:0] ct_Led
);
  import clock_base_pkg::*;

  logic       rx_valid;
  logic [7:0] rx_data;

  pkt_state_t      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      len_q, len_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0][7:0] sr_q, sr_d;
  logic [7:0]      data_led_q, data_led_d;
  logic [3:0]      ok_q, ok_d;
  logic [3:0]      err_q, err_d;
  logic [7:0]      led_q, led_d;
  logic [7:0]      acc_x;
  logic [2:0]      first_idx;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (CLK),
    .rst_n    (reset),
    .rx_line  (ct_UartRx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      sr_q       <= '0;
      data_led_q <= '0;
      ok_q       <= '0;
      err_q      <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      sr_q       <= sr_d;
      data_led_q <= data_led_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      led_q      <= led_d;
    end
  end

  // Before the final shift, the packet's first byte sits at sr[len-2]
  assign acc_x     = acc_q ^ rx_data;
  assign first_idx = 3'(len_q - 4'd2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    acc_d      = acc_q;
    sr_d       = sr_q;
    data_led_d = data_led_q;
    ok_d       = ok_q;
    err_d      = err_q;
    if (rx_valid) begin
      case (state_q)
        HUNT: begin
          if (rx_data == SOF) state_d = LEN;
        end
        LEN: begin
          if (rx_data != 8'd0 && rx_data <= MAX_LEN) begin
            cnt_d   = rx_data[3:0];
            len_d   = rx_data[3:0];
            acc_d   = '0;
            state_d = DATA;
          end else begin
            err_d   = err_q + 4'd1;
            state_d = HUNT;
          end
        end
        DATA: begin
          acc_d = acc_x;
          sr_d  = {sr_q[6:0], rx_data};
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = HUNT;
            if (acc_x == 8'd0) begin
              data_led_d = (len_q == 4'd1) ? rx_data : sr_q[first_idx];
              ok_d       = ok_q + 4'd1;
            end else begin
              err_d = err_q + 4'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    led_d = sw ? {ok_d, err_d} : data_led_d;
  end

  assign ct_Led = led_q;

endmodule

// File: tb/tb_clock_base_top.sv
// tb/tb_clock_base_top.sv - scoreboard bench driving serial packets and checking both LED views
module tb_clock_base_top;

  localparam int CPB = 32;

  typedef struct {
    string      name;
    logic [7:0] value;
  } exp_t;

  typedef logic [7:0] byte_q_t[$];

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       sw = 1'b0;
  logic       ct_UartRx = 1'b1;
  logic [7:0] ct_Led;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  clock_base_top #(.CLKS_PER_BIT(CPB)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .sw        (sw),
    .ct_UartRx (ct_UartRx),
    .ct_Led    (ct_Led)
  );

  always #5 CLK = ~CLK;

  // Monitor: compares the LED output against each queued expectation on the falling edge
  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (ct_Led !== e.value) begin
          miscompares++;
          $display("FAIL %s: ct_Led=%h expected %h", e.name, ct_Led, e.value);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    ct_UartRx = 1'b0;
    repeat (CPB) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      ct_UartRx = b[i];
      repeat (CPB) @(posedge CLK);
    end
    ct_UartRx = stop;
    repeat (CPB) @(posedge CLK);
    ct_UartRx = 1'b1;
    repeat (CPB) @(posedge CLK);
  endtask

  task automatic send_seq(input byte_q_t bs);
    foreach (bs[i]) send_byte(bs[i], 1'b1);
  endtask

  task automatic expect_led(input string name, input logic s, input logic [7:0] v);
    exp_t e;
    int   t;
    sw = s;
    repeat (4) @(posedge CLK);
    e.name  = name;
    e.value = v;
    exp_q.push_back(e);
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(posedge CLK);
      t++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL %s: no comparison within 100 cycles, expected %h", name, v);
      exp_q.delete();
    end
  endtask

  task automatic expect_views(input string name, input logic [7:0] data_v, input logic [7:0] stat_v);
    expect_led({name, "_data"}, 1'b0, data_v);
    expect_led({name, "_stats"}, 1'b1, stat_v);
  endtask

  initial begin : stimulus
    byte_q_t seq;

    #100 reset = 1'b1;
    repeat (4) @(posedge CLK);
    expect_views("reset", 8'h00, 8'h00);

    seq = '{8'hF4, 8'h7E, 8'h03, 8'h55, 8'h57, 8'h02};
    send_seq(seq);
    expect_views("good_pkt", 8'h55, 8'h10);

    seq = '{8'h41, 8'h7E, 8'h06, 8'hC0, 8'hF0, 8'h02, 8'h02, 8'hFC, 8'hFF};
    send_seq(seq);
    expect_views("bad_xor", 8'h55, 8'h11);

    seq = '{8'h7E, 8'h09};
    send_seq(seq);
    expect_views("len9", 8'h55, 8'h12);

    seq = '{8'h7E, 8'h02, 8'h66, 8'h66};
    send_seq(seq);
    expect_views("after_len_err", 8'h66, 8'h22);

    seq = '{8'h7E, 8'h02};
    send_seq(seq);
    send_byte(8'hA5, 1'b0);
    seq = '{8'h12, 8'h12};
    send_seq(seq);
    expect_views("framing_drop", 8'h12, 8'h32);

    seq = '{8'h7E, 8'h02};
    send_seq(seq);
    ct_UartRx = 1'b0;
    repeat (CPB / 2 - 4) @(posedge CLK);
    ct_UartRx = 1'b1;
    repeat (2 * CPB) @(posedge CLK);
    seq = '{8'h33, 8'h33};
    send_seq(seq);
    expect_views("glitch", 8'h33, 8'h42);

    seq = '{8'h7E, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
    send_seq(seq);
    expect_views("max_len", 8'h01, 8'h52);

    seq = '{8'h7E, 8'h00};
    send_seq(seq);
    expect_views("len0", 8'h01, 8'h53);

    seq = '{8'h7E, 8'h01, 8'h00};
    send_seq(seq);
    expect_views("len1", 8'h00, 8'h63);

    seq = '{8'h7E, 8'h03, 8'h7E, 8'h10, 8'h6E};
    send_seq(seq);
    expect_views("sof_in_data", 8'h7E, 8'h73);

    seq = '{8'h7E, 8'h03, 8'hAA};
    send_seq(seq);
    ct_UartRx = 1'b0;
    repeat (CPB * 3) @(posedge CLK);
    reset = 1'b0;
    #100;
    ct_UartRx = 1'b1;
    reset = 1'b1;
    repeat (4) @(posedge CLK);
    expect_views("mid_reset", 8'h00, 8'h00);

    seq = '{8'h7E, 8'h02, 8'h99, 8'h99};
    send_seq(seq);
    expect_views("post_reset", 8'h99, 8'h10);

    for (int n = 0; n < 15; n++) begin
      seq = '{8'h7E, 8'h01, 8'h00};
      send_seq(seq);
    end
    expect_views("ok_wrap", 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    done = 1'b1;
    $finish;
  end

endmodule
